// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: walks all radix-2 stages, issuing RAM read beats.
// Optional stage_done pulse output enabled by macro FFT_SEQ_STAGE_DONE_EN.
module fft_stage_sequencer #(
   parameter int FFT_N      = 10,
   parameter int GAP_CYCLES = 4,
   parameter int STAGE_W    = $clog2(FFT_N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               iready,
   output logic               busy,
   output logic               done,
   output logic               oact,
   output logic [1:0]         octrl,
   output logic [FFT_N-2:0]   oaddr,
`ifdef FFT_SEQ_STAGE_DONE_EN
   output logic [STAGE_W-1:0] ostage,
   output logic               stage_done
`else
   output logic [STAGE_W-1:0] ostage
`endif
);

   localparam int CNT_W = FFT_N - 1;

   localparam logic [7:0]         GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam logic [STAGE_W-1:0] STG_LAST = STAGE_W'(FFT_N - 1);
   localparam logic [STAGE_W-1:0] STG_ONE  = STAGE_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] CTRL_S0   = 2'b10;
   localparam logic [1:0] CTRL_IDLE = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0]   r_cnt;
   logic [STAGE_W-1:0] r_stage;
   logic [7:0]         r_gcnt;

   logic               r_busy;
   logic               r_done;
   logic               r_oact;
   logic [1:0]         r_octrl;
   logic [CNT_W-1:0]   r_oaddr;
   logic [STAGE_W-1:0] r_ostage;

   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_oact_nxt;
   logic [1:0]         w_octrl_nxt;
   logic [CNT_W-1:0]   w_oaddr_nxt;
   logic [STAGE_W-1:0] w_ostage_nxt;

   logic w_run;
   logic w_stage0;
   logic w_issue;
   logic w_last_beat;
   logic w_last_gap;
   logic w_last_stage;

   // Beat issue: stage 0 obeys iready per beat; later stages only at pair start.
   assign w_run        = (r_state == S_RUN);
   assign w_stage0     = (r_stage == '0);
   assign w_issue      = w_run & (w_stage0 ? iready : (r_cnt[0] | iready));
   assign w_last_beat  = w_issue & (&r_cnt);
   assign w_last_gap   = (r_state == S_DRAIN) & (r_gcnt == GAP_LAST);
   assign w_last_stage = (r_stage == STG_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_last_beat) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_last_gap) begin
               w_state_nxt = w_last_stage ? S_FIN : S_RUN;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Beat, stage and gap counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_stage <= '0;
         r_gcnt  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt   <= '0;
                  r_stage <= '0;
               end
            end
            S_RUN: begin
               if (w_issue) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
               if (w_last_beat) begin
                  r_gcnt <= '0;
               end
            end
            S_DRAIN: begin
               r_gcnt <= r_gcnt + 8'd1;
               if (w_last_gap && !w_last_stage) begin
                  r_stage <= r_stage + STG_ONE;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Next values for the registered outputs.
   always_comb begin
      w_busy_nxt   = (r_state != S_IDLE);
      w_done_nxt   = 1'b0;
      w_oact_nxt   = 1'b0;
      w_octrl_nxt  = CTRL_IDLE;
      w_oaddr_nxt  = r_oaddr;
      w_ostage_nxt = r_ostage;
      unique case (r_state)
         S_RUN: begin
            if (w_issue) begin
               w_oact_nxt   = 1'b1;
               w_oaddr_nxt  = r_cnt;
               w_ostage_nxt = r_stage;
               w_octrl_nxt  = w_stage0 ? CTRL_S0 : {r_cnt[0], r_cnt[0]};
            end
         end
         S_FIN: begin
            w_done_nxt = 1'b1;
         end
         default: begin
            w_done_nxt = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_oact   <= 1'b0;
         r_octrl  <= CTRL_IDLE;
         r_oaddr  <= '0;
         r_ostage <= '0;
      end else begin
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_oact   <= w_oact_nxt;
         r_octrl  <= w_octrl_nxt;
         r_oaddr  <= w_oaddr_nxt;
         r_ostage <= w_ostage_nxt;
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign oact   = r_oact;
   assign octrl  = r_octrl;
   assign oaddr  = r_oaddr;
   assign ostage = r_ostage;

`ifdef FFT_SEQ_STAGE_DONE_EN
   logic r_sdone;

   // Stage-done pulse on the last drain cycle of each stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sdone <= 1'b0;
      end else begin
         r_sdone <= w_last_gap;
      end
   end

   assign stage_done = r_sdone;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (FFT_N=3, GAP_CYCLES=2).
// Cycle k inputs are applied before edge k; cycle k outputs sampled after it.
module tb_fft_stage_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       iready;
   logic       busy;
   logic       done;
   logic       oact;
   logic [1:0] octrl;
   logic [1:0] oaddr;
   logic [1:0] ostage;
`ifdef FFT_SEQ_STAGE_DONE_EN
   logic       stage_done;
   logic       a_sd [64];
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic       a_act  [64];
   logic       a_busy [64];
   logic       a_done [64];
   logic [1:0] a_ctl  [64];
   logic [1:0] a_addr [64];
   logic [1:0] a_stg  [64];

   fft_stage_sequencer #(
      .FFT_N(3),
      .GAP_CYCLES(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .iready(iready),
      .busy(busy),
      .done(done),
      .oact(oact),
      .octrl(octrl),
      .oaddr(oaddr),
`ifdef FFT_SEQ_STAGE_DONE_EN
      .ostage(ostage),
      .stage_done(stage_done)
`else
      .ostage(ostage)
`endif
   );

   always #5 clk = ~clk;

   task automatic step(input logic s, input logic r, input logic rs);
      start  = s;
      iready = r;
      reset  = rs;
      @(posedge clk);
      #1;
      a_act[cyc]  = oact;
      a_busy[cyc] = busy;
      a_done[cyc] = done;
      a_ctl[cyc]  = octrl;
      a_addr[cyc] = oaddr;
      a_stg[cyc]  = ostage;
`ifdef FFT_SEQ_STAGE_DONE_EN
      a_sd[cyc]   = stage_done;
`endif
      cyc++;
   endtask

   task automatic do_reset();
      start  = 1'b0;
      iready = 1'b1;
      reset  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      total++;
      if ({a_busy[0], a_done[0], a_act[0], a_ctl[0], a_addr[0], a_stg[0]}
          !== 9'b0) begin
         bad++;
         $display("FAIL reset_vals got=%b%b%b %b %b %b want=all zero",
                  a_busy[0], a_done[0], a_act[0], a_ctl[0], a_addr[0],
                  a_stg[0]);
      end
      for (int c = 1; c < 3; c++) begin
         total++;
         if (a_act[c] !== 1'b0 || a_busy[c] !== 1'b0) begin
            bad++;
            $display("FAIL reset_wins cyc=%0d act=%b busy=%b want=0 0",
                     c, a_act[c], a_busy[c]);
         end
      end
   endtask

   task automatic test_nominal();
      int  bc [12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
      int  ba [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      int  bk [12] = '{2, 2, 2, 2, 0, 3, 0, 3, 0, 3, 0, 3};
      int  bs [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
      logic e;
      do_reset();
      for (int c = 0; c < 22; c++) step(c == 0, 1'b1, 1'b0);
      for (int c = 0; c < 22; c++) begin
         e = 1'b0;
         for (int k = 0; k < 12; k++) if (bc[k] == c) e = 1'b1;
         total++;
         if (a_act[c] !== e) begin
            bad++;
            $display("FAIL nom_oact cyc=%0d got=%b want=%b", c, a_act[c], e);
         end
         total++;
         if (a_busy[c] !== (c >= 1 && c <= 19)) begin
            bad++;
            $display("FAIL nom_busy cyc=%0d got=%b", c, a_busy[c]);
         end
         total++;
         if (a_done[c] !== (c == 19)) begin
            bad++;
            $display("FAIL nom_done cyc=%0d got=%b", c, a_done[c]);
         end
`ifdef FFT_SEQ_STAGE_DONE_EN
         total++;
         if (a_sd[c] !== (c == 6 || c == 12 || c == 18)) begin
            bad++;
            $display("FAIL nom_stage_done cyc=%0d got=%b", c, a_sd[c]);
         end
`endif
      end
      for (int k = 0; k < 12; k++) begin
         total++;
         if (a_addr[bc[k]] !== 2'(ba[k]) || a_ctl[bc[k]] !== 2'(bk[k]) ||
             a_stg[bc[k]] !== 2'(bs[k])) begin
            bad++;
            $display("FAIL nom_beat cyc=%0d addr=%0d ctl=%b stg=%0d want %0d %0d %0d",
                     bc[k], a_addr[bc[k]], a_ctl[bc[k]], a_stg[bc[k]],
                     ba[k], bk[k], bs[k]);
         end
      end
      total++;
      if (a_addr[5] !== 2'd3 || a_stg[5] !== 2'd0 || a_ctl[5] !== 2'b00) begin
         bad++;
         $display("FAIL nom_drain_hold addr=%0d stg=%0d ctl=%b want 3 0 00",
                  a_addr[5], a_stg[5], a_ctl[5]);
      end
   endtask

   task automatic test_stall_pair();
      int  bc [12] = '{1, 2, 3, 4, 7, 8, 10, 11, 14, 15, 16, 17};
      int  ba [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      int  bk [12] = '{2, 2, 2, 2, 0, 3, 0, 3, 0, 3, 0, 3};
      logic e;
      do_reset();
      for (int c = 0; c < 23; c++) step(c == 0, !(c == 8 || c == 9), 1'b0);
      for (int c = 0; c < 23; c++) begin
         e = 1'b0;
         for (int k = 0; k < 12; k++) if (bc[k] == c) e = 1'b1;
         total++;
         if (a_act[c] !== e) begin
            bad++;
            $display("FAIL pair_oact cyc=%0d got=%b want=%b", c, a_act[c], e);
         end
         total++;
         if (a_done[c] !== (c == 20)) begin
            bad++;
            $display("FAIL pair_done cyc=%0d got=%b", c, a_done[c]);
         end
      end
      for (int k = 0; k < 12; k++) begin
         total++;
         if (a_addr[bc[k]] !== 2'(ba[k]) || a_ctl[bc[k]] !== 2'(bk[k])) begin
            bad++;
            $display("FAIL pair_beat cyc=%0d addr=%0d ctl=%b want %0d %0d",
                     bc[k], a_addr[bc[k]], a_ctl[bc[k]], ba[k], bk[k]);
         end
      end
      total++;
      if (a_busy[20] !== 1'b1 || a_busy[21] !== 1'b0) begin
         bad++;
         $display("FAIL pair_busy_end got=%b%b want=10", a_busy[20], a_busy[21]);
      end
   endtask

   task automatic test_stall_s0();
      int bc [4] = '{1, 3, 4, 5};
      do_reset();
      for (int c = 0; c < 22; c++) step(c == 0, c != 2, 1'b0);
      total++;
      if (a_act[2] !== 1'b0) begin
         bad++;
         $display("FAIL s0_gap got=%b want=0", a_act[2]);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (a_act[bc[k]] !== 1'b1 || a_addr[bc[k]] !== 2'(k) ||
             a_ctl[bc[k]] !== 2'b10) begin
            bad++;
            $display("FAIL s0_beat cyc=%0d act=%b addr=%0d ctl=%b want 1 %0d 10",
                     bc[k], a_act[bc[k]], a_addr[bc[k]], a_ctl[bc[k]], k);
         end
      end
      total++;
      if (a_done[19] !== 1'b0 || a_done[20] !== 1'b1) begin
         bad++;
         $display("FAIL s0_done_shift got=%b%b want=01", a_done[19], a_done[20]);
      end
   endtask

   task automatic test_restart_ignored();
      do_reset();
      for (int c = 0; c < 22; c++) step(c == 0 || c == 6, 1'b1, 1'b0);
      for (int c = 0; c < 22; c++) begin
         total++;
         if (a_done[c] !== (c == 19)) begin
            bad++;
            $display("FAIL restart_done cyc=%0d got=%b", c, a_done[c]);
         end
      end
      total++;
      if (a_act[7] !== 1'b1 || a_addr[7] !== 2'd0 || a_stg[7] !== 2'd1) begin
         bad++;
         $display("FAIL restart_beat act=%b addr=%0d stg=%0d want 1 0 1",
                  a_act[7], a_addr[7], a_stg[7]);
      end
      total++;
      if (a_busy[20] !== 1'b0) begin
         bad++;
         $display("FAIL restart_busy got=%b want=0", a_busy[20]);
      end
   endtask

   task automatic test_abort();
      do_reset();
      for (int c = 0; c < 33; c++) step(c == 0 || c == 12, 1'b1, c == 9);
      total++;
      if (a_act[10] !== 1'b0 || a_busy[10] !== 1'b0 || a_stg[10] !== 2'd0 ||
          a_ctl[10] !== 2'b00) begin
         bad++;
         $display("FAIL abort_idle act=%b busy=%b stg=%0d ctl=%b want 0 0 0 00",
                  a_act[10], a_busy[10], a_stg[10], a_ctl[10]);
      end
      for (int c = 0; c < 31; c++) begin
         total++;
         if (a_done[c] !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done cyc=%0d got=%b", c, a_done[c]);
         end
      end
      total++;
      if (a_act[12] !== 1'b0 || a_act[13] !== 1'b1 || a_addr[13] !== 2'd0 ||
          a_ctl[13] !== 2'b10) begin
         bad++;
         $display("FAIL abort_restart act=%b%b addr=%0d ctl=%b want 01 0 10",
                  a_act[12], a_act[13], a_addr[13], a_ctl[13]);
      end
      total++;
      if (a_done[31] !== 1'b1) begin
         bad++;
         $display("FAIL abort_done got=%b want=1", a_done[31]);
      end
   endtask

   initial begin
      start  = 1'b0;
      iready = 1'b1;
      reset  = 1'b1;
      test_reset();
      test_nominal();
      test_stall_pair();
      test_stall_s0();
      test_restart_ignored();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Control-side source for the FFT RAM→butterfly path.
- On start, walks all FFT_N radix-2 stages.
- Issues one RAM read address per beat, with a valid (oact) and an operand-mux control code (octrl).
- Output feeds the RAM read port and the RAM/butterfly pipeline bridge directly downstream.
- Inserts a fixed drain gap between stages so in-place write-back lands before the next stage reads.

Parameters:
FFT_N, 10, log2 of FFT points; RAM depth 2^(FFT_N-1) words, each word holds an even/odd pair.
GAP_CYCLES, 4, idle cycles between stages (pipeline drain); legal range 1..255.
STAGE_W, $clog2(FFT_N), width of stage index.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  single-cycle request to begin a transform; ignored unless idle
iready  input  1  downstream can accept a new beat pair
busy  output  1  high from first beat through done cycle inclusive
done  output  1  one-cycle pulse after final stage drain
oact  output  1  beat valid
octrl  output  2  mux code: 10 stage 0; 00 even beat stage≥1; 11 odd beat stage≥1
oaddr  output  FFT_N-1  RAM read address
ostage  output  STAGE_W  current stage index

Behaviour:
- All outputs registered.
- Reset values: busy 0, done 0, oact 0, octrl 00, oaddr 0, ostage 0.
- Reset mid-transform aborts to IDLE on the next edge; no done pulse.
- Parameters: M = 2^(FFT_N-1); cnt is an FFT_N-1-bit beat counter; gcnt is an 8-bit gap counter.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 → RUN with cnt=0, stage=0.
  - The first beat is presented on the cycle after start (1-cycle latency).
- RUN beat emission (per issued beat):
  - oact=1, oaddr=cnt, ostage=stage.
  - octrl=10 when stage==0, else {cnt[0],cnt[0]}.
- RUN stall rule, stage 0:
  - iready sampled every beat.
  - iready=0 → oact=0, cnt holds.
- RUN stall rule, stage≥1:
  - iready sampled only before an even beat (cnt[0]==0).
  - Once an even beat issues, the odd beat issues on the very next cycle regardless of iready; the bridge requires consecutive pairs.
  - A stall therefore never splits a pair.
- RUN exit: after the beat with cnt==M-1 → DRAIN, gcnt=0, cnt wraps to 0.
- DRAIN:
  - oact=0, octrl=00; oaddr and ostage hold.
  - Counts exactly GAP_CYCLES cycles, ignoring iready.
  - Then: if stage<FFT_N-1 → stage+1, RUN; else → FIN.
- FIN: done=1 and busy=1 for one cycle, then IDLE with busy=0 on the following cycle.
- start while busy: ignored, no restart.
- start coincident with reset: reset wins.
- Total cycles with no stalls: FFT_N*(M+GAP_CYCLES)+1 from start to done.

Optional Feature:
Macro FFT_SEQ_STAGE_DONE_EN.
- When defined: adds output stage_done (1 bit, reset 0).
  - Pulses for one cycle on the last DRAIN cycle of every stage, including the final stage, so it coincides with the cycle before FIN.
  - Used by the twiddle ROM bank-switch logic.
- When undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- FFT_N=3, GAP_CYCLES=2, start at cycle 0, iready=1:
  - oact=1 in cycles 1-4, 7-10, 13-16.
  - oaddr 0,1,2,3 each stage.
  - octrl 10,10,10,10 then 00,11,00,11 for stages 1 and 2.
  - done=1 only in cycle 19; busy 1 in cycles 1-19, 0 at cycle 20.
- Same config, iready=0 in cycles 8-9 (stage 1, odd beat pending):
  - addr 1 still issues at cycle 8; oact=0 in cycle 9; addr 2 issues at cycle 10.
  - Every 00 beat is immediately followed by an 11 beat; done shifts +1 cycle.
- Stage 0, iready=0 in cycle 2: oaddr 0 at cycle 1, gap at cycle 2, oaddr 1 at cycle 3, all octrl=10.
- start pulsed again at cycle 6 while busy: no effect; done still at cycle 19.
- reset asserted at cycle 9: cycle 10 shows oact=0, busy=0, ostage=0, octrl=00; no done pulse; a new start at cycle 12 gives first beat at cycle 13.
- With FFT_SEQ_STAGE_DONE_EN, default run from the first scenario: stage_done high exactly in cycles 6, 12, 18.
